// File: rtl/puf2usrp_burst_ctrl.sv
// Burst scheduler ahead of puf2usrp: gates a continuous I/Q stream into
// fixed-length tlast-terminated bursts separated by a programmable idle gap.
module puf2usrp_burst_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    stop,
  input  logic [CNT_WIDTH-1:0]    cfg_burst_len,
  input  logic [CNT_WIDTH-1:0]    cfg_gap,
  input  logic [CNT_WIDTH-1:0]    cfg_num_bursts,
  input  logic [2*DATA_WIDTH-1:0] in_tdata,
  input  logic                    in_tvalid,
  output logic                    in_tready,
  output logic [2*DATA_WIDTH-1:0] out_tdata,
  output logic                    out_tvalid,
  output logic                    out_tlast,
  input  logic                    out_tready,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_WIDTH-1:0]    burst_cnt,
  output logic [31:0]             drop_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BURST,
    S_GAP
  } state_t;

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] len_q, gap_q, nb_q;
  logic [CNT_WIDTH-1:0] beat_cnt, gap_cnt;
  logic [CNT_WIDTH-1:0] burst_cnt_inc;
  logic                 stop_pending;
  logic                 beat, last_beat, run_end, launch;

  always_comb begin
    out_tdata     = in_tdata;
    busy          = (state != S_IDLE);
    out_tvalid    = (state == S_BURST) && in_tvalid;
    in_tready     = (state == S_BURST) ? out_tready : 1'b1;
    out_tlast     = out_tvalid && (beat_cnt == len_q - ONE);
    beat          = out_tvalid && out_tready;
    last_beat     = beat && out_tlast;
    burst_cnt_inc = burst_cnt + ONE;
    launch        = start && !stop;
    // A stop arriving together with the final beat ends the run at that beat.
    run_end       = ((nb_q != '0) && (burst_cnt_inc == nb_q)) || stop_pending || stop;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (launch) state_nxt = S_BURST;
      S_BURST: begin
        if (last_beat) begin
          if (run_end)           state_nxt = S_IDLE;
          else if (gap_q == '0)  state_nxt = S_BURST;
          else                   state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (stop)                        state_nxt = S_IDLE;
        else if (gap_cnt == gap_q - ONE) state_nxt = S_BURST;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      len_q        <= '0;
      gap_q        <= '0;
      nb_q         <= '0;
      beat_cnt     <= '0;
      gap_cnt      <= '0;
      burst_cnt    <= '0;
      drop_cnt     <= '0;
      stop_pending <= 1'b0;
      done         <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (launch) begin
            len_q        <= (cfg_burst_len == '0) ? ONE : cfg_burst_len;
            gap_q        <= cfg_gap;
            nb_q         <= cfg_num_bursts;
            beat_cnt     <= '0;
            gap_cnt      <= '0;
            burst_cnt    <= '0;
            drop_cnt     <= '0;
            stop_pending <= 1'b0;
          end
        end
        S_BURST: begin
          if (stop) stop_pending <= 1'b1;
          if (last_beat) begin
            beat_cnt  <= '0;
            gap_cnt   <= '0;
            burst_cnt <= burst_cnt_inc;
            if (run_end) begin
              done         <= 1'b1;
              stop_pending <= 1'b0;
            end
          end else if (beat) begin
            beat_cnt <= beat_cnt + ONE;
          end
        end
        S_GAP: begin
          gap_cnt <= gap_cnt + ONE;
          if (in_tvalid && (drop_cnt != '1)) drop_cnt <= drop_cnt + 32'd1;
          if (stop) done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_puf2usrp_burst_ctrl.sv
// Scoreboard bench for puf2usrp_burst_ctrl: directed runs push expected beats,
// a negedge monitor pops and compares every output beat.
module tb_puf2usrp_burst_ctrl;

  localparam int DW = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [CW-1:0] cfg_burst_len = '0;
  logic [CW-1:0] cfg_gap = '0;
  logic [CW-1:0] cfg_num_bursts = '0;
  logic [2*DW-1:0] in_tdata;
  logic          in_tvalid = 1'b1;
  logic          in_tready;
  logic [2*DW-1:0] out_tdata;
  logic          out_tvalid;
  logic          out_tlast;
  logic          out_tready;
  logic          busy;
  logic          done;
  logic [CW-1:0] burst_cnt;
  logic [31:0]   drop_cnt;

  puf2usrp_burst_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .cfg_burst_len(cfg_burst_len), .cfg_gap(cfg_gap), .cfg_num_bursts(cfg_num_bursts),
    .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tready(in_tready),
    .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tlast(out_tlast),
    .out_tready(out_tready), .busy(busy), .done(done),
    .burst_cnt(burst_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          beats_seen = 0;
  int          done_seen = 0;
  logic [31:0] src = 32'h1000_0000;
  bit          rnd_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Source: data is a sequence number that advances on every accepted handshake
  initial begin
    logic hs;
    in_tdata   = src;
    out_tready = 1'b1;
    forever begin
      @(negedge clk);
      hs = in_tvalid && in_tready;
      @(posedge clk);
      #1;
      if (hs) src = src + 32'd1;
      in_tdata   = src;
      out_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) done_seen++;
      if (out_tvalid && out_tready) begin
        beats_seen++;
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_beat: got data %0h tlast %0b, expected no beat", out_tdata, out_tlast);
        end else begin
          e = q.pop_front();
          chk("beat_data", out_tdata, e.d);
          chk("beat_tlast", 32'(out_tlast), 32'(e.l));
        end
      end
    end
  end

  task automatic push_beats(input logic [31:0] base, input int unsigned len,
                            input int unsigned gap, input int unsigned nbeats);
    exp_t e;
    for (int unsigned i = 0; i < nbeats; i++) begin
      e.d = base + 32'((i / len) * (len + gap) + (i % len));
      e.l = ((i % len) == len - 1);
      q.push_back(e);
    end
  endtask

  // Called at posedge+2; the start cycle drains the current source word.
  task automatic start_run(input int unsigned len, input int unsigned gap,
                           input int unsigned nb, input int unsigned nbeats,
                           output int d0, output int b0);
    int unsigned elen;
    elen           = (len == 0) ? 1 : len;
    cfg_burst_len  = CW'(len);
    cfg_gap        = CW'(gap);
    cfg_num_bursts = CW'(nb);
    d0             = done_seen;
    b0             = beats_seen;
    push_beats(src + 32'd1, elen, gap, nbeats);
    start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
  endtask

  task automatic wait_beats(input int tgt, input string name);
    int budget = 2000;
    while (beats_seen < tgt && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (beats_seen < tgt) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d beats expected %0d", name, beats_seen, tgt);
    end
  endtask

  task automatic end_run(input string name, input int d0,
                         input int unsigned exp_bursts, input int unsigned exp_drop);
    int budget = 2000;
    while (done_seen == d0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    repeat (4) @(posedge clk);
    #2;
    chk({name, "_done_pulses"}, 32'(done_seen - d0), 32'd1);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_burst_cnt"}, 32'(burst_cnt), 32'(exp_bursts));
    chk({name, "_drop_cnt"}, drop_cnt, 32'(exp_drop));
    chk({name, "_pending"}, 32'(q.size()), 32'd0);
  endtask

  initial begin
    int d0, b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_burst_cnt", 32'(burst_cnt), 32'd0);
    chk("rst_drop_cnt", drop_cnt, 32'd0);
    chk("rst_out_tvalid", 32'(out_tvalid), 32'd0);
    chk("rst_out_tlast", 32'(out_tlast), 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #2;

    // 3 bursts of 4 with 2 gap cycles
    start_run(4, 2, 3, 12, d0, b0);
    wait_beats(b0 + 12, "t1");
    #2;
    chk("t1_busy_after_last", 32'(busy), 32'd0);
    chk("t1_done_after_last", 32'(done), 32'd1);
    end_run("t1", d0, 3, 4);

    // back-to-back bursts
    start_run(3, 0, 2, 6, d0, b0);
    end_run("t2", d0, 2, 0);

    // stop mid-burst: burst 2 still completes
    start_run(8, 1, 0, 16, d0, b0);
    wait_beats(b0 + 13, "t3");
    #2 stop = 1'b1;
    @(posedge clk);
    #2 stop = 1'b0;
    end_run("t3", d0, 2, 1);

    // stop on third gap cycle
    start_run(4, 10, 0, 4, d0, b0);
    wait_beats(b0 + 4, "t4");
    #2;
    @(posedge clk);
    #2;
    @(posedge clk);
    #2 stop = 1'b1;
    @(posedge clk);
    #2 stop = 1'b0;
    end_run("t4", d0, 1, 3);
    repeat (20) @(posedge clk);
    #2 chk("t4_no_more_beats", 32'(beats_seen - b0), 32'd4);

    // random backpressure
    rnd_ready = 1'b1;
    start_run(5, 3, 2, 10, d0, b0);
    end_run("t5", d0, 2, 3);
    rnd_ready = 1'b0;
    chk("t5_beat_total", 32'(beats_seen - b0), 32'd10);

    // zero length means one-beat bursts; start during a run is ignored
    start_run(0, 1, 3, 3, d0, b0);
    wait_beats(b0 + 1, "t6");
    #2;
    start          = 1'b1;
    cfg_burst_len  = CW'(7);
    cfg_gap        = CW'(5);
    cfg_num_bursts = CW'(9);
    @(posedge clk);
    #2 start = 1'b0;
    end_run("t6", d0, 3, 2);

    // asynchronous reset mid-burst
    start_run(4, 2, 0, 10, d0, b0);
    wait_beats(b0 + 10, "t7");
    #2;
    chk("t7_pre_burst_cnt", 32'(burst_cnt), 32'd2);
    chk("t7_pre_drop_cnt", drop_cnt, 32'd4);
    chk("t7_pre_tvalid", 32'(out_tvalid), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("t7_rst_tvalid", 32'(out_tvalid), 32'd0);
    chk("t7_rst_tlast", 32'(out_tlast), 32'd0);
    chk("t7_rst_busy", 32'(busy), 32'd0);
    chk("t7_rst_burst_cnt", 32'(burst_cnt), 32'd0);
    chk("t7_rst_drop_cnt", drop_cnt, 32'd0);
    repeat (4) @(posedge clk);
    #2;
    chk("t7_no_done", 32'(done_seen - d0), 32'd0);
    chk("t7_pending", 32'(q.size()), 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #2;

    // recovery after reset
    start_run(2, 0, 1, 2, d0, b0);
    end_run("t8", d0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1);
  end

endmodule
